// File: rtl/spell_mem_spi_pkg.sv
// Shared constants and FSM state encoding for the spell-memory SPI protocol.
// Imported by both the SPI initiator and the SPI target.
package spell_mem_spi_pkg;

    localparam logic [7:0]  CMD_READ        = 8'h03;
    localparam logic [7:0]  CMD_WRITE       = 8'h02;
    localparam int unsigned BYTE_BITS       = 8;
    localparam int unsigned ADDR_FIELD_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } spi_state_e;

endpackage

// File: rtl/spell_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses on the synchronized level.
module spell_sync_edge
    import spell_mem_spi_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              level_c;

    always_comb begin
        sync_d  = (sync_q << 1) | STAGES'(din);
        level_c = sync_q[STAGES-1];
        prev_d  = level_c;
        rise_d  = level_c & ~prev_q;
        fall_d  = ~level_c & prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spell_mem_spi_target.sv
// SPI mode-0 target fronting a byte memory that a host port can also preload/inspect.
// Define SPELL_MEM_SPI_TARGET_BURST_EN to keep streaming bytes at incrementing addresses.
module spell_mem_spi_target
    import spell_mem_spi_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 spi_wr_strobe
);

    localparam int unsigned DEPTH    = 2**ADDR_BITS;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(BYTE_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_FIELD_BITS - 1);

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [6:0]             tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   is_wr_q, is_wr_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [7:0]             host_rdata_q, host_rdata_d;
    logic [7:0]             mem_rd_q, mem_rd_d;

    logic                   cs_s, mosi_s, clk_rise, clk_fall;
    logic [7:0]             rx_byte_c;
    logic                   spi_we_c, mem_we_c;
    logic [ADDR_BITS-1:0]   mem_waddr_c;
    logic [7:0]             mem_wdata_c;

    logic [7:0] mem [DEPTH];

    spell_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_clk),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    // Plain level synchronizers for chip select and data.
    always_comb begin
        cs_sync_d   = (cs_sync_q << 1) | SYNC_STAGES'(spi_cs);
        mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi);
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_s;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        is_wr_d     = is_wr_q;
        spi_we_c    = 1'b0;
        rx_byte_c   = {shift_q, mosi_s};

        if (cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_prev_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (clk_rise) begin
                        shift_d   = rx_byte_c[6:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BYTE_BIT) begin
                            bit_cnt_d = '0;
                            if (rx_byte_c == CMD_READ) begin
                                is_wr_d = 1'b0;
                                state_d = ST_ADDR;
                            end else if (rx_byte_c == CMD_WRITE) begin
                                is_wr_d = 1'b1;
                                state_d = ST_ADDR;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    miso_d = 1'b0;
                    // Upper address bits shift out of the narrower index register.
                    if (clk_rise) begin
                        addr_d    = (addr_q << 1) | ADDR_BITS'(mosi_s);
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_ADDR_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (clk_rise) begin
                        shift_d   = rx_byte_c[6:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BYTE_BIT) begin
                            bit_cnt_d = '0;
                            spi_we_c  = is_wr_q & rst_n;
`ifdef SPELL_MEM_SPI_TARGET_BURST_EN
                            addr_d    = addr_q + ADDR_BITS'(1);
`else
                            state_d   = ST_IGNORE;
`endif
                        end
                    end else if (clk_fall && !is_wr_q) begin
                        // First falling edge of a byte loads the prefetched memory word.
                        if (bit_cnt_q == '0) begin
                            miso_d = mem_rd_q[7];
                            tx_d   = mem_rd_q[6:0];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: miso_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end

        wr_strobe_d = spi_we_c;
    end

    // Single write port: an SPI commit takes priority over a same-cycle host write.
    always_comb begin
        mem_we_c     = spi_we_c | host_we;
        mem_waddr_c  = spi_we_c ? addr_q : host_addr;
        mem_wdata_c  = spi_we_c ? rx_byte_c : host_wdata;
        mem_rd_d     = mem[addr_q];
        host_rdata_d = mem[host_addr];
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
        mem_rd_q <= mem_rd_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            is_wr_q      <= 1'b0;
            wr_strobe_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            is_wr_q      <= is_wr_d;
            wr_strobe_q  <= wr_strobe_d;
            cs_prev_q    <= cs_prev_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign spi_miso      = miso_q;
    assign spi_wr_strobe = wr_strobe_q;
    assign host_rdata    = host_rdata_q;

endmodule

// File: tb/tb_spell_mem_spi_target.sv
// Scoreboard bench for spell_mem_spi_target: stimulus pushes expectations, a monitor pops and compares.
module tb_spell_mem_spi_target;

    localparam int unsigned ADDR_BITS = 9;
    localparam int          HALF      = 60;

    typedef struct {
        string      name;
        logic [9:0] val;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 spi_cs;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 host_we;
    logic [ADDR_BITS-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic [7:0]           host_rdata;
    logic                 spi_wr_strobe;

    spell_mem_spi_target #(
        .ADDR_BITS   (ADDR_BITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_cs        (spi_cs),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .spi_wr_strobe (spi_wr_strobe)
    );

    exp_t host_q[$];
    exp_t spi_q[$];
    exp_t strb_q[$];
    exp_t misc_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   host_seq = 0;
    int   spi_seq  = 0;
    int   strb_seq = 0;
    int   misc_seq = 0;
    logic [7:0] spi_obs = 8'h00;

    int   strb_total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic void cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expectation whenever the bench flags a new DUT response.
    int   host_seen = 0;
    int   spi_seen  = 0;
    int   strb_seen = 0;
    int   misc_seen = 0;
    int   strb_cnt  = 0;
    logic strb_prev = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (spi_wr_strobe === 1'b1) begin
            cmp("strobe_width", {9'b0, strb_prev}, 10'd0);
            if (!strb_prev) strb_cnt++;
        end
        strb_prev = (spi_wr_strobe === 1'b1);

        if (host_seen != host_seq) begin
            host_seen = host_seq;
            if (host_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL host_unexpected: got 0x%0h expected none", host_rdata);
            end else begin
                e = host_q.pop_front();
                cmp(e.name, {2'b00, host_rdata}, e.val);
            end
        end
        if (spi_seen != spi_seq) begin
            spi_seen = spi_seq;
            if (spi_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL spi_unexpected: got 0x%0h expected none", spi_obs);
            end else begin
                e = spi_q.pop_front();
                cmp(e.name, {2'b00, spi_obs}, e.val);
            end
        end
        if (strb_seen != strb_seq) begin
            strb_seen = strb_seq;
            e = strb_q.pop_front();
            cmp(e.name, 10'(strb_cnt), e.val);
        end
        if (misc_seen != misc_seq) begin
            misc_seen = misc_seq;
            e = misc_q.pop_front();
            cmp(e.name, {spi_miso, spi_wr_strobe, host_rdata}, e.val);
        end
    end

    task automatic host_write(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    task automatic host_read(input string name, input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
        exp_t x;
        @(posedge clk); #1;
        host_addr = a;
        x.name = name; x.val = {2'b00, d};
        host_q.push_back(x);
        @(posedge clk); #1;
        host_seq++;
    endtask

    task automatic check_strb(input string name, input int exp);
        exp_t x;
        @(posedge clk); #1;
        x.name = name; x.val = 10'(exp);
        strb_q.push_back(x);
        strb_seq++;
    endtask

    // Mode-0 transaction; tx/exp_rx are MSB-first left-aligned; rst_bit < 0 means no reset.
    task automatic spi_txn(input string name, input logic [39:0] tx, input logic [39:0] exp_rx,
                           input int nbits, input int rst_bit);
        exp_t       x;
        logic [7:0] rx;
        rx = 8'h00;
        for (int b = 0; b < nbits / 8; b++) begin
            x.name = $sformatf("%s_byte%0d", name, b);
            x.val  = {2'b00, exp_rx[39-8*b -: 8]};
            spi_q.push_back(x);
        end
        @(posedge clk); #1;
        spi_cs = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) rst_n = 1'b0;
            spi_mosi = tx[39-i];
            #HALF;
            spi_clk = 1'b1;
            rx = {rx[6:0], spi_miso};
            if (i % 8 == 7) begin
                spi_obs = rx;
                spi_seq++;
            end
            #HALF;
            spi_clk = 1'b0;
        end
        spi_mosi = 1'b0;
        #HALF;
        spi_cs = 1'b1;
        #(4*HALF);
        if (rst_bit >= 0) begin
            rst_n = 1'b1;
            #(4*HALF);
        end
    endtask

    initial begin
        exp_t x;
        rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
        strb_total = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        x.name = "reset_outputs"; x.val = 10'd0;
        misc_q.push_back(x);
        misc_seq++;

        // Preload and SPI read back.
        host_write(9'h012, 8'hA5);
        host_read("host_preload_012", 9'h012, 8'hA5);
        spi_txn("read_012", {8'h03, 8'h00, 8'h12, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00, 8'hA5, 8'h00}, 32, -1);
        check_strb("strobe_after_read", strb_total);

        // Full SPI write to the top address.
        spi_txn("write_1ff", {8'h02, 8'h01, 8'hFF, 8'h3C, 8'h00}, 40'h0, 32, -1);
        strb_total = strb_total + 1;
        check_strb("strobe_after_write", strb_total);
        host_read("host_1ff_after_write", 9'h1FF, 8'h3C);

        // Write aborted after 4 data bits leaves memory alone.
        host_write(9'h020, 8'h5A);
        spi_txn("partial_write", {8'h02, 8'h00, 8'h20, 8'hF0, 8'h00}, 40'h0, 28, -1);
        check_strb("strobe_after_partial", strb_total);
        host_read("host_020_after_partial", 9'h020, 8'h5A);

        // Unknown command is ignored.
        host_write(9'h000, 8'hEE);
        spi_txn("bad_cmd", {8'h9F, 8'h01, 8'hFF, 8'h55, 8'h00}, 40'h0, 32, -1);
        check_strb("strobe_after_bad_cmd", strb_total);
        host_read("host_1ff_after_bad_cmd", 9'h1FF, 8'h3C);
        host_read("host_012_after_bad_cmd", 9'h012, 8'hA5);

        // Two data bytes: wraps 0x1FF -> 0x000 only in burst builds.
        spi_txn("burst_write", {8'h02, 8'h01, 8'hFF, 8'h11, 8'h22}, 40'h0, 40, -1);
`ifdef SPELL_MEM_SPI_TARGET_BURST_EN
        strb_total = strb_total + 2;
        check_strb("strobe_after_burst", strb_total);
        host_read("host_1ff_after_burst", 9'h1FF, 8'h11);
        host_read("host_000_after_burst", 9'h000, 8'h22);
`else
        strb_total = strb_total + 1;
        check_strb("strobe_after_burst", strb_total);
        host_read("host_1ff_after_burst", 9'h1FF, 8'h11);
        host_read("host_000_after_burst", 9'h000, 8'hEE);
`endif

        // Reset at bit 28 of a write aborts it; a following read is normal.
        host_write(9'h040, 8'h99);
        spi_txn("reset_write", {8'h02, 8'h00, 8'h40, 8'h77, 8'h00}, 40'h0, 32, 28);
        check_strb("strobe_after_reset_write", strb_total);
        host_read("host_040_after_reset", 9'h040, 8'h99);
        spi_txn("read_040", {8'h03, 8'h00, 8'h40, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00, 8'h99, 8'h00}, 32, -1);

        // Upper address bits are ignored; top address read.
        spi_txn("read_fe12", {8'h03, 8'hFE, 8'h12, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00, 8'hA5, 8'h00}, 32, -1);
        spi_txn("read_1ff", {8'h03, 8'h01, 8'hFF, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00, 8'h11, 8'h00}, 32, -1);
        check_strb("strobe_final", strb_total);

        repeat (10) @(posedge clk);
        cmp("host_queue_drained", 10'(host_q.size()), 10'd0);
        cmp("spi_queue_drained", 10'(spi_q.size()), 10'd0);
        cmp("strobe_queue_drained", 10'(strb_q.size()), 10'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
